// File: rtl/i2c_vector_tx.sv
// Write-only I2C master. It snapshots a signed byte vector on start and sends
// START, address+W, N_ELEM data bytes and STOP. A NACK on any byte ends the frame early.
module i2c_vector_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned N_ELEM     = 26,
    parameter logic [6:0]  SLAVE_ADDR = 7'h42
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic signed [7:0] input_vector [N_ELEM-1:0],
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              scl_oe,
    output logic              busy,
    output logic              done,
    output logic              ack_err
);

    localparam int IDX_W = $clog2(N_ELEM + 1);
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START_C,
        BIT,
        STOP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [1:0]        quarter_q, quarter_d;
    logic [3:0]        bit_q, bit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              nack_q, nack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ack_err_q, ack_err_d;
    logic              sda_oe_q, sda_oe_d;
    logic              scl_oe_q, scl_oe_d;
    logic signed [7:0] shadow_q [N_ELEM-1:0];
    logic signed [7:0] shadow_d [N_ELEM-1:0];
    logic              qtick;
    logic [7:0]        tx_byte;
    logic [7:0]        tx_shift;

    assign qtick = busy_q && (presc_q == PRE_W'(CLK_DIV - 1));

    // Sequencing: one step per quarter-period tick while busy.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        presc_d   = presc_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        nack_d    = nack_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        shadow_d  = shadow_q;

        if (busy_q) begin
            presc_d = qtick ? '0 : presc_q + PRE_W'(1);
        end

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d   = START_C;
                    busy_d    = 1'b1;
                    ack_err_d = 1'b0;
                    presc_d   = '0;
                    quarter_d = '0;
                    bit_d     = '0;
                    idx_d     = '0;
                    nack_d    = 1'b0;
                    shadow_d  = input_vector;
                end
            end
            START_C: begin
                if (qtick) begin
                    if (quarter_q == 2'd1) begin
                        state_d   = BIT;
                        quarter_d = '0;
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end
            BIT: begin
                if (qtick) begin
                    quarter_d = quarter_q + 2'd1;
                    // The slave's ACK is taken while SCL has been high for a full quarter.
                    if (bit_q == 4'd8 && quarter_q == 2'd2) begin
                        nack_d = sda_in;
                    end
                    if (quarter_q == 2'd3) begin
                        if (bit_q != 4'd8) begin
                            bit_d = bit_q + 4'd1;
                        end else begin
                            bit_d = '0;
                            if (nack_q || idx_q == IDX_W'(N_ELEM)) begin
                                state_d   = STOP;
                                ack_err_d = nack_q;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                    end
                end
            end
            STOP: begin
                if (qtick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd3) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line enables come from the next state, so the pads change on the same edge as the FSM.
    always_comb begin
        tx_byte  = (idx_d == '0) ? {SLAVE_ADDR, 1'b0}
                                 : $unsigned(shadow_q[idx_d - IDX_W'(1)]);
        tx_shift = tx_byte << bit_d[2:0];
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
        unique case (state_d)
            START_C: sda_oe_d = 1'b1;
            BIT: begin
                scl_oe_d = (quarter_d < 2'd2);
                sda_oe_d = (bit_d != 4'd8) && !tx_shift[7];
            end
            STOP: begin
                scl_oe_d = (quarter_d == 2'd0);
                sda_oe_d = (quarter_d < 2'd2);
            end
            default: begin
                sda_oe_d = 1'b0;
                scl_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            nack_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            sda_oe_q  <= 1'b0;
            scl_oe_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop sees pre-edge values of the others.
            state_q   <= state_d;
            presc_q   <= presc_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            nack_q    <= nack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            sda_oe_q  <= sda_oe_d;
            scl_oe_q  <= scl_oe_d;
        end
    end

    // NOTE: the shadow array is data only, loaded on every accept, so it carries no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign sda_oe  = sda_oe_q;
    assign scl_oe  = scl_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_vector_tx.sv
// Bench for i2c_vector_tx: an ACKing slave/bus decoder drives sda_in. Decoded frames,
// latency and flags are compared with a byte-list model built from the vector.
module tb_i2c_vector_tx;

    localparam int         N    = 26;
    localparam logic [6:0] ADDR = 7'h42;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start_a, start_b;
    logic signed [7:0] vec_a [N-1:0];
    logic signed [7:0] vec_b [N-1:0];
    logic              sda_in_a, sda_in_b;
    logic              sda_oe_a, scl_oe_a, busy_a, done_a, ack_err_a;
    logic              sda_oe_b, scl_oe_b, busy_b, done_b, ack_err_b;

    bit sel;
    bit slave_pull;
    int nack_at;

    int n_checks = 0;
    int n_fail   = 0;

    // Bus observer and slave state.
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       scl_now, sda_now;
    logic [7:0] shreg = '0;
    logic [7:0] bus_q[$];
    int         bit_cnt   = 0;
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         done_cnt  = 0;

    logic sda_oe_m, scl_oe_m, busy_m, done_m, ack_err_m;
    assign sda_oe_m  = sel ? sda_oe_b  : sda_oe_a;
    assign scl_oe_m  = sel ? scl_oe_b  : scl_oe_a;
    assign busy_m    = sel ? busy_b    : busy_a;
    assign done_m    = sel ? done_b    : done_a;
    assign ack_err_m = sel ? ack_err_b : ack_err_a;

    assign sda_in_a = ~(sda_oe_a | (!sel && slave_pull));
    assign sda_in_b = ~(sda_oe_b | (sel && slave_pull));

    i2c_vector_tx dut_a (
        .clk          (clk),
        .rst          (rst_n),
        .start        (start_a),
        .input_vector (vec_a),
        .sda_in       (sda_in_a),
        .sda_oe       (sda_oe_a),
        .scl_oe       (scl_oe_a),
        .busy         (busy_a),
        .done         (done_a),
        .ack_err      (ack_err_a)
    );

    i2c_vector_tx #(.CLK_DIV(1)) dut_b (
        .clk          (clk),
        .rst          (rst_n),
        .start        (start_b),
        .input_vector (vec_b),
        .sda_in       (sda_in_b),
        .sda_oe       (sda_oe_b),
        .scl_oe       (scl_oe_b),
        .busy         (busy_b),
        .done         (done_b),
        .ack_err      (ack_err_b)
    );

    // Decode the selected bus on falling clk edges and play the slave's ACK/NACK.
    initial begin
        forever begin
            @(negedge clk);
            scl_now = ~scl_oe_m;
            sda_now = ~(sda_oe_m | slave_pull);
            if (done_m) done_cnt++;
            if (scl_now && prev_scl) begin
                if (prev_sda && !sda_now) begin
                    start_cnt++;
                    bit_cnt = 0;
                end else if (!prev_sda && sda_now) begin
                    stop_cnt++;
                end
            end else if (scl_now && !prev_scl) begin
                if (bit_cnt < 8) begin
                    shreg = {shreg[6:0], sda_now};
                    bit_cnt++;
                end else if (bit_cnt == 8) begin
                    bus_q.push_back(shreg);
                    bit_cnt = 9;
                end
            end else if (!scl_now && prev_scl) begin
                if (bit_cnt == 8) begin
                    slave_pull = (bus_q.size() != nack_at);
                end else if (bit_cnt == 9) begin
                    slave_pull = 1'b0;
                    bit_cnt    = 0;
                end
            end
            prev_scl = scl_now;
            prev_sda = sda_now;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prep(input int nack_pos);
        nack_at    = nack_pos;
        bus_q.delete();
        bit_cnt    = 0;
        start_cnt  = 0;
        stop_cnt   = 0;
        done_cnt   = 0;
        slave_pull = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check($sformatf("%s/busy_on_accept", tag), busy_m, 1);
        check($sformatf("%s/ack_err_clear", tag), ack_err_m, 0);
    endtask

    // Model: the frame is the address byte followed by the vector, cut after the NACKed byte.
    task automatic run_txn(input string tag, input int nack_pos, input int restart_at);
        logic [7:0]  all_q[$];
        logic [31:0] obs;
        int          n_sent, exp_cyc, cnt;
        bit          got, exp_err;
        prep(nack_pos);
        all_q.push_back({ADDR, 1'b0});
        for (int i = 0; i < N; i++) all_q.push_back(sel ? vec_b[i] : vec_a[i]);
        exp_err = (nack_pos >= 0 && nack_pos <= N);
        n_sent  = exp_err ? nack_pos + 1 : N + 1;
        exp_cyc = (sel ? 1 : 4) * (2 + 36 * n_sent + 4);

        pulse_start(tag);
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 8000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == restart_at) begin
                for (int i = 0; i < N; i++) vec_a[i] = 8'($urandom);
                if (sel) start_b = 1'b1;
                else     start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            got = done_m;
        end
        check($sformatf("%s/done_seen", tag), got, 1);
        check($sformatf("%s/latency", tag), cnt, exp_cyc);
        check($sformatf("%s/busy_at_done", tag), busy_m, 0);
        check($sformatf("%s/ack_err", tag), ack_err_m, exp_err);
        @(posedge clk);
        #1;
        check($sformatf("%s/done_width", tag), done_m, 0);
        repeat (20) @(posedge clk);
        #1;
        check($sformatf("%s/done_count", tag), done_cnt, 1);
        check($sformatf("%s/n_bytes", tag), bus_q.size(), n_sent);
        for (int i = 0; i < n_sent; i++) begin
            obs = (i < bus_q.size()) ? 32'(bus_q[i]) : 32'hxxxx_xxxx;
            check($sformatf("%s/byte%0d", tag, i), obs, all_q[i]);
        end
        check($sformatf("%s/start_cond", tag), start_cnt, 1);
        check($sformatf("%s/stop_cond", tag), stop_cnt, 1);
    endtask

    initial begin
        int  cnt;
        bit  found;
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        sel        = 1'b0;
        nack_at    = -1;
        slave_pull = 1'b0;
        for (int i = 0; i < N; i++) begin
            vec_a[i] = '0;
            vec_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst/sda_oe_a", sda_oe_a, 0);
        check("rst/scl_oe_a", scl_oe_a, 0);
        check("rst/busy_a", busy_a, 0);
        check("rst/done_a", done_a, 0);
        check("rst/ack_err_a", ack_err_a, 0);
        check("rst/sda_oe_b", sda_oe_b, 0);
        check("rst/scl_oe_b", scl_oe_b, 0);
        check("rst/busy_b", busy_b, 0);
        check("rst/done_b", done_b, 0);
        check("rst/ack_err_b", ack_err_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < N; k++) vec_a[k] = 8'(k - 13);
        run_txn("ramp", -1, 0);
        run_txn("nack_addr", 0, 0);

        for (int i = 0; i < N; i++) vec_a[i] = 8'($urandom);
        run_txn("after_nack", -1, 0);
        run_txn("nack_d5", 5, 0);

        for (int i = 0; i < N; i++) vec_a[i] = 8'($urandom);
        run_txn("restart", -1, 500);

        // Reset while SCL is high in the middle of data byte 10.
        for (int i = 0; i < N; i++) vec_a[i] = 8'($urandom);
        prep(-1);
        pulse_start("rst_mid");
        cnt   = 0;
        found = 1'b0;
        while (!found && cnt < 8000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (bus_q.size() == 10 && bit_cnt == 4 && !scl_oe_a) found = 1'b1;
        end
        check("rst_mid/reached", found, 1);
        check("rst_mid/busy_before", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid/sda_oe", sda_oe_a, 0);
        check("rst_mid/scl_oe", scl_oe_a, 0);
        check("rst_mid/busy", busy_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < N; i++) vec_a[i] = 8'($urandom);
        run_txn("post_rst", -1, 0);

        sel = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < N; i++) vec_b[i] = 8'h80;
        run_txn("div1_80", -1, 0);
        for (int i = 0; i < N; i++) vec_b[i] = 8'($urandom);
        run_txn("div1_rand_nack", int'($urandom_range(1, N)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_vector_tx.md
Name: i2c_vector_tx

Overview:
- I2C controller (write-only master) that sends one 26-element signed 8-bit feature vector to the I2C vector receiver on the speech-recognition board.
- On a start request it snapshots the vector and issues START, a 7-bit address with W, then 26 data bytes, then STOP.
- Open-drain pads sit outside this block. It drives active-high pull-low enables and reads the sampled SDA level.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-period (≥1); one SCL bit = 4*CLK_DIV cycles
- N_ELEM, 26, number of vector elements sent
- SLAVE_ADDR, 7'h42, 7-bit target address

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  1-cycle request; accepted only when busy=0
- input_vector  input  8 signed x [N_ELEM-1:0]  vector to send; element 0 first
- sda_in  input  1  synchronized SDA level (1 = released/high)
- sda_oe  output  1  1 = pull SDA low
- scl_oe  output  1  1 = pull SCL low
- busy  output  1  high from accept to done
- done  output  1  1-cycle pulse at end of transaction
- ack_err  output  1  last transaction ended on NACK; sticky until next accepted start

Behaviour:
- Reset (rst=0, async): sda_oe=0, scl_oe=0, busy=0, done=0, ack_err=0, FSM=IDLE, counters=0. Reset mid-transfer releases both lines immediately. No STOP is generated.
- Tick: prescaler counts 0..CLK_DIV-1 and emits qtick on wrap. Prescaler runs only when busy=1 and is cleared on accept.
- Accept (IDLE, start=1):
  - Latch input_vector into an internal shadow array.
  - busy=1 next cycle; ack_err cleared.
  - start while busy=1 is ignored. Later input_vector changes do not affect the current transfer.
- FSM states and transitions:
  - IDLE
  - START_C: SDA low, SCL released, 2 quarters; then BIT.
  - BIT: 9 bits per byte, 4 quarters per bit.
    - q0, q1: SCL low. SDA is set at start of q0: MSB first for bits 0-7, released for bit 8 (ACK).
    - q2, q3: SCL released.
    - ACK is sampled from sda_in on the qtick ending q2 of bit 8. sda_in=1 means NACK.
  - Byte 0 is {SLAVE_ADDR,1'b0}. Bytes 1..N_ELEM are shadow[0..N_ELEM-1], sent as two's-complement bit patterns.
  - After each ACK: next byte, or STOP after byte N_ELEM.
  - NACK on any byte: set ack_err=1, go to STOP. No further bytes are sent.
  - STOP:
    - q0: SCL low, SDA low.
    - q1: SCL released, SDA low.
    - q2, q3: SCL released, SDA released.
    - Then DONE.
  - DONE: done=1 for one cycle, busy=0, back to IDLE.
- Element index counter is $clog2(N_ELEM+1) bits. Bit counter is 4 bits (0..8). Quarter counter is 2 bits.
- Latency, full transfer: 2 + 9*4*(N_ELEM+1) + 4 quarters. With defaults: 978 quarters = 3912 clk cycles from the accept edge to the done edge.
- Latency, NACK at address: 2 + 36 + 4 = 42 quarters.
- SDA transitions only while SCL is pulled low, except the START and STOP edges.
- No clock stretching and no arbitration. sda_in is used only at ACK sample points.

Test Plan:
- Reset, defaults, sda_in tied to an ACKing slave model, vector[k]=k-13, pulse start:
  - Decoded bus shows START, 0x84, bytes 0xF3,0xF4,…,0x0C, STOP.
  - done pulses exactly 3912 cycles after accept; ack_err=0.
- Slave NACKs address (sda_in=1 at first ACK):
  - STOP follows immediately; done after 168 cycles (42 quarters); ack_err=1.
  - A following ACKed transfer clears ack_err.
- NACK on data byte 5:
  - Exactly 5 data bytes appear on the bus, then STOP; ack_err=1.
- Change input_vector and pulse start again mid-transfer:
  - Second start is ignored.
  - Bus carries only the originally latched values; a single done pulse.
- Assert rst=0 while SCL is high in the middle of byte 10:
  - sda_oe=0, scl_oe=0, busy=0 in the same cycle.
  - After release, a new start produces a complete, correct transfer.
- CLK_DIV=1 with vector all 8'h80:
  - Every data byte reads 0x80; total 978 cycles; SDA is stable while SCL is released, except at START and STOP.
